// File: rtl/nested_loop_pkg.sv
// rtl/nested_loop_pkg.sv - shared types and default widths for the nested-loop address generator
package nested_loop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DEF_NUM_MAX_LOOPS     = 7;
  localparam int DEF_LOG_NUM_MAX_LOOPS = 3;
  localparam int DEF_ADDRESS_WIDTH     = 32;
  localparam int DEF_STRIDE_WIDTH      = 32;
  localparam int DEF_NUM_ITER_WIDTH    = 32;

endpackage

// File: rtl/nested_loop_agen_level.sv
// rtl/nested_loop_agen_level.sv - one loop level: iteration counter, level address and latched stride/limit
module loop_level_ctr
  import nested_loop_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int STRIDE_WIDTH   = DEF_STRIDE_WIDTH,
  parameter int NUM_ITER_WIDTH = DEF_NUM_ITER_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      advance,
  input  logic                      reload,
  input  logic                      active,
  input  logic [ADDRESS_WIDTH-1:0]  base,
  input  logic [ADDRESS_WIDTH-1:0]  reload_addr,
  input  logic [STRIDE_WIDTH-1:0]   stride,
  input  logic [NUM_ITER_WIDTH-1:0] num_iter,
  output logic                      at_max,
  output logic [ADDRESS_WIDTH-1:0]  lvl_addr,
  output logic [ADDRESS_WIDTH-1:0]  next_addr
);

  logic [NUM_ITER_WIDTH-1:0] iters_q;
  logic [NUM_ITER_WIDTH-1:0] last_q;
  logic [ADDRESS_WIDTH-1:0]  stride_q;
  logic [ADDRESS_WIDTH-1:0]  stride_ext;

  generate
    if (STRIDE_WIDTH >= ADDRESS_WIDTH) begin : g_trunc
      assign stride_ext = stride[ADDRESS_WIDTH-1:0];
    end else begin : g_sext
      assign stride_ext = {{(ADDRESS_WIDTH-STRIDE_WIDTH){stride[STRIDE_WIDTH-1]}}, stride};
    end
  endgenerate

  // A zero count behaves as one, so the stored terminal index is 0 in both cases.
  always_ff @(posedge clk) begin
    if (reset) begin
      iters_q  <= '0;
      last_q   <= '0;
      stride_q <= '0;
      lvl_addr <= '0;
    end else if (load) begin
      iters_q  <= '0;
      last_q   <= (num_iter == '0) ? '0 : num_iter - 1'b1;
      stride_q <= stride_ext;
      lvl_addr <= base;
    end else if (advance) begin
      iters_q  <= iters_q + 1'b1;
      lvl_addr <= next_addr;
    end else if (reload) begin
      iters_q  <= '0;
      lvl_addr <= reload_addr;
    end
  end

  assign next_addr = lvl_addr + stride_q;
  assign at_max    = !active || (iters_q == last_q);

endmodule

// File: rtl/nested_loop_agen.sv
// rtl/nested_loop_agen.sv - multi-level nested-loop address generator with ready/valid output
module nested_loop_agen
  import nested_loop_pkg::*;
#(
  parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
  parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
  parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
  parameter int STRIDE_WIDTH      = DEF_STRIDE_WIDTH,
  parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [ADDRESS_WIDTH-1:0]                cfg_base,
  input  logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   cfg_stride,
  input  logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] cfg_num_iter,
  input  logic [LOG_NUM_MAX_LOOPS:0]              cfg_num_loops,
  input  logic                                    start,
  input  logic                                    abort,
  output logic                                    busy,
  output logic [ADDRESS_WIDTH-1:0]                addr_out,
  output logic                                    addr_valid,
  input  logic                                    addr_ready,
  output logic                                    addr_last,
  output logic                                    done
);

  localparam int LW = LOG_NUM_MAX_LOOPS + 1;

  state_t state_q, state_d;
  logic [LW-1:0] loops_eff, loops_q;
  logic load, fire, last, carry;
  logic [NUM_MAX_LOOPS-1:0] active, lvl_done, adv, rel;
  logic [ADDRESS_WIDTH-1:0] lvl_addr  [NUM_MAX_LOOPS];
  logic [ADDRESS_WIDTH-1:0] next_addr [NUM_MAX_LOOPS];
  logic [ADDRESS_WIDTH-1:0] carry_addr;

  assign loops_eff = (cfg_num_loops > LW'(NUM_MAX_LOOPS)) ? LW'(NUM_MAX_LOOPS) : cfg_num_loops;
  assign last      = &lvl_done;
  assign fire      = (state_q == RUN) && addr_ready && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) loops_q <= loops_eff;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (loops_eff == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort)              state_d = IDLE;
        else if (fire && last)  state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Odometer carry chain: the first level not at its limit advances, all levels below it reload.
  always_comb begin
    carry      = fire && !last;
    adv        = '0;
    rel        = '0;
    carry_addr = '0;
    for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
      adv[i] = carry && !lvl_done[i];
      rel[i] = carry && lvl_done[i];
      if (adv[i]) carry_addr = next_addr[i];
      carry  = carry && lvl_done[i];
    end
  end

  generate
    for (genvar g = 0; g < NUM_MAX_LOOPS; g++) begin : g_lvl
      assign active[g] = loops_q > LW'(g);
      loop_level_ctr #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .STRIDE_WIDTH  (STRIDE_WIDTH),
        .NUM_ITER_WIDTH(NUM_ITER_WIDTH)
      ) u_lvl (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .advance    (adv[g]),
        .reload     (rel[g]),
        .active     (active[g]),
        .base       (cfg_base),
        .reload_addr(carry_addr),
        .stride     (cfg_stride[g*STRIDE_WIDTH +: STRIDE_WIDTH]),
        .num_iter   (cfg_num_iter[g*NUM_ITER_WIDTH +: NUM_ITER_WIDTH]),
        .at_max     (lvl_done[g]),
        .lvl_addr   (lvl_addr[g]),
        .next_addr  (next_addr[g])
      );
    end
  endgenerate

  assign busy       = (state_q != IDLE);
  assign addr_valid = (state_q == RUN);
  assign addr_out   = (state_q == RUN) ? lvl_addr[0] : '0;
  assign addr_last  = (state_q == RUN) && last;
  assign done       = (state_q == FINISH) && !abort;

endmodule

// File: tb/tb_nested_loop_agen.sv
// tb/tb_nested_loop_agen.sv - randomized self-checking bench against an arithmetic nested-loop model
module tb_nested_loop_agen;

  localparam int N = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cfg_base = '0;
  logic [32*N-1:0] cfg_stride = '0;
  logic [32*N-1:0] cfg_num_iter = '0;
  logic [3:0]    cfg_num_loops = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic [31:0]   addr_out;
  logic          addr_valid;
  logic          addr_ready = 1'b0;
  logic          addr_last;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cur_stride [N];
  logic [31:0] cur_iter   [N];
  logic [31:0] exp_q [$];

  nested_loop_agen dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_base     (cfg_base),
    .cfg_stride   (cfg_stride),
    .cfg_num_iter (cfg_num_iter),
    .cfg_num_loops(cfg_num_loops),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .addr_out     (addr_out),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr_last    (addr_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Beat n is a mixed-radix number; each digit weights its level's stride.
  task automatic build_expected(input logic [31:0] base, input int loops);
    int l, total, rem, d, e [N];
    logic [31:0] a;
    exp_q.delete();
    l = (loops > N) ? N : loops;
    total = (l == 0) ? 0 : 1;
    for (int i = 0; i < l; i++) begin
      e[i] = (cur_iter[i] == 0) ? 1 : int'(cur_iter[i]);
      total *= e[i];
    end
    for (int n = 0; n < total; n++) begin
      rem = n;
      a = base;
      for (int i = 0; i < l; i++) begin
        d = rem % e[i];
        rem = rem / e[i];
        a = a + 32'(d) * cur_stride[i];
      end
      exp_q.push_back(a);
    end
  endtask

  // ctl: 0 normal, 1 start pulse while busy, 2 abort at beat ctl_beat, 3 reset at beat ctl_beat.
  // ready_pct: 0..100 random acceptance, -1 fixed 1,0,0 pattern.
  task automatic walk(input string name, input logic [31:0] base, input int loops,
                      input int ready_pct, input int ctl, input int ctl_beat);
    int idx, cyc, total;
    bit stopped;
    build_expected(base, loops);
    total = exp_q.size();
    @(negedge clk);
    cfg_base = base;
    cfg_num_loops = 4'(loops);
    for (int i = 0; i < N; i++) begin
      cfg_stride[i*32 +: 32]   = cur_stride[i];
      cfg_num_iter[i*32 +: 32] = cur_iter[i];
    end
    start = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, ":busy_t1"}, 64'(busy), 64'd1);
    check({name, ":valid_t1"}, 64'(addr_valid), 64'(total != 0));
    idx = 0;
    cyc = 0;
    stopped = 0;
    while (!done && !stopped && cyc < 20000) begin
      if (ready_pct < 0) addr_ready = (cyc % 3 == 0);
      else addr_ready = ($urandom_range(99, 0) < ready_pct);
      if (ctl == 1 && cyc == 2) begin
        start = 1'b1;
        cfg_base = ~base;
        cfg_num_loops = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (addr_valid) begin
        if (idx < total) begin
          check($sformatf("%s:addr[%0d]", name, idx), 64'(addr_out), 64'(exp_q[idx]));
          check($sformatf("%s:last[%0d]", name, idx), 64'(addr_last), 64'(idx == total - 1));
        end else begin
          check({name, ":extra_beat"}, 64'(idx), 64'(total - 1));
        end
        if ((ctl == 2 || ctl == 3) && idx == ctl_beat) begin
          if (ctl == 2) abort = 1'b1;
          else reset = 1'b1;
          addr_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          reset = 1'b0;
          check({name, ":ctl_valid"}, 64'(addr_valid), 64'd0);
          check({name, ":ctl_busy"}, 64'(busy), 64'd0);
          check({name, ":ctl_done"}, 64'(done), 64'd0);
          check({name, ":ctl_addr"}, 64'(addr_out), 64'd0);
          check({name, ":ctl_last"}, 64'(addr_last), 64'd0);
          @(negedge clk);
          check({name, ":ctl_no_done"}, 64'(done), 64'd0);
          stopped = 1;
        end
        if (addr_ready) idx++;
      end
      if (!stopped) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    addr_ready = 1'b0;
    if (!stopped) begin
      check({name, ":done_seen"}, 64'(done), 64'd1);
      check({name, ":beats"}, 64'(idx), 64'(total));
      check({name, ":busy_at_done"}, 64'(busy), 64'd1);
      if (ready_pct == 100) check({name, ":cycles"}, 64'(cyc), 64'(total));
      @(negedge clk);
      check({name, ":done_once"}, 64'(done), 64'd0);
      check({name, ":busy_idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cur_stride[i] = '0;
      cur_iter[i]   = '0;
    end
  endtask

  task automatic set_basic();
    clear_cfg();
    cur_iter[0] = 3; cur_stride[0] = 32'h4;
    cur_iter[1] = 2; cur_stride[1] = 32'h40;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(addr_valid), 64'd0);
    check("rst_last", 64'(addr_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(addr_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);

    set_basic();
    walk("basic", 32'h100, 2, 100, 0, 0);
    walk("bp", 32'h100, 2, -1, 0, 0);

    clear_cfg();
    cur_iter[0] = 2; cur_stride[0] = 32'h10;
    cur_iter[1] = 0; cur_stride[1] = 32'h100;
    cur_iter[2] = 2; cur_stride[2] = 32'h1000;
    walk("zero_cnt", 32'h0, 3, 100, 0, 0);
    walk("l0", 32'h55, 0, 100, 0, 0);

    clear_cfg();
    cur_iter[0] = 3; cur_stride[0] = 32'hFFFF_FFF8;
    walk("neg", 32'h4, 1, 100, 0, 0);

    clear_cfg();
    cur_iter[0] = 5; cur_stride[0] = 32'h1;
    walk("busy_start", 32'h200, 1, 30, 1, 0);
    set_basic();
    walk("abort", 32'h100, 2, 100, 2, 2);
    walk("relaunch1", 32'h100, 2, 100, 0, 0);
    walk("reset", 32'h100, 2, 100, 3, 1);
    walk("relaunch2", 32'h100, 2, 100, 0, 0);

    clear_cfg();
    for (int i = 0; i < N; i++) begin
      cur_iter[i] = 2;
      cur_stride[i] = 32'(1 << i);
    end
    walk("max", 32'h0, 7, 100, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        cur_iter[i]   = 32'($urandom_range(3, 0));
        cur_stride[i] = $urandom;
      end
      walk($sformatf("rand%0d", r), $urandom, int'($urandom_range(15, 0)), 60, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
